multicycle_ctrl: RTL
====================

# multicycle_ctrl

Main control unit for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback through a Moore state machine, and drives every datapath select and write enable, including `ImmSrc` for the immediate extender. The ALU operation comes from a combinational sub-decoder. The unit sits between the instruction register and the shared-memory multicycle datapath.

## Interface
- No parameters.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `op` in 7: instruction register bits [6:0].
- `funct3` in 3: instruction register bits [14:12].
- `funct7b5` in 1: instruction register bit 30.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: unified memory has completed the current access.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: loads the instruction register and OldPC.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result select; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select; 00 = PC, 01 = OldPC, 10 = rd1, 11 = zero.
- `ALUSrcB` out 2: ALU B select; 00 = rd2, 01 = ImmExt, 10 = constant 4.
- `ALUControl` out 3: ALU operation.
- `ImmSrc` out 3: immediate format, using the `Imm_pkg` encodings.
- `illegal` out 1: one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LINK, LUI, AUIPC.
- **FETCH**
  - Drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10.
  - IRWrite and PCWrite assert only in the cycle where `mem_ready`=1; that is also the cycle that moves to DECODE. Otherwise the FSM stays in FETCH.
- **DECODE**
  - Computes ALUOut = OldPC+ImmExt (ALUSrcA=01, ALUSrcB=01, add).
  - Next state by opcode:
    - 0000011 and 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - 1100111 → JALR.
    - 0110111 → LUI.
    - 0010111 → AUIPC.
    - Any other opcode → FETCH with `illegal`=1.
- **MEMADR:** computes rd1+ImmExt. Next state is MEMREAD when op[5]=0, MEMWRITE when op[5]=1.
- **MEMREAD:** AdrSrc=1. Stays until `mem_ready`=1, then goes to MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1, then FETCH.
- **MEMWRITE:** AdrSrc=1, MemWrite=1 held until `mem_ready`=1, then FETCH.
- **EXECR / EXECI:** rd1 op rd2 / rd1 op ImmExt, with ALUOp=funct. Both go to ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1, then FETCH.
- **BRANCH:** rd1−rd2 (ALUOp=sub), ResultSrc=00. PCWrite = `zero` XOR funct3[0] (beq/bne). Then FETCH.
- **JAL:** OldPC+4 (ALUSrcA=01, ALUSrcB=10), ResultSrc=00, PCWrite=1, then ALUWB.
- **JALR:** rd1+ImmExt, ResultSrc=10, PCWrite=1 (the datapath clears bit 0), then LINK.
- **LINK:** OldPC+4, then ALUWB.
- **LUI:** zero+ImmExt (ALUSrcA=11). **AUIPC:** OldPC+ImmExt. Both go to ALUWB.
- **ImmSrc:** combinational from `op`, valid in every state.
  - IMM_TypeI for 0000011, 0010011, 1100111.
  - IMM_TypeS for 0100011.
  - IMM_TypeB for 1100011.
  - IMM_TypeU for 0110111 and 0010111.
  - IMM_TypeJ for 1101111.
  - IMM_TypeI for anything else.
- **alu_decoder:**
  - ALUOp=add → 000; ALUOp=sub → 001.
  - ALUOp=funct, by funct3:
    - 000 → add 000, or sub 001 when `{op[5],funct7b5}`=11.
    - 010 → slt 101.
    - 100 → xor 100.
    - 110 → or 011.
    - 111 → and 010.
    - Others → 000.
- All outputs not listed for a state are 0.

## Timing
- The state register updates on the rising edge of `clk`. `rst_n` low forces FETCH immediately.
- While `rst_n` is low, every write enable (`PCWrite`, `IRWrite`, `MemWrite`, `RegWrite`) is 0 and `illegal` is 0. Selects show their FETCH values.
- Reset deasserted in the middle of an instruction: execution restarts at FETCH. No partial register write occurs.
- Cycle counts with `mem_ready` tied high:

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw | 4 |
  | R-type, I-type ALU | 4 |
  | beq/bne | 3 |
  | jal | 4 |
  | jalr | 5 |
  | lui, auipc | 4 |

- Each cycle with `mem_ready` low adds one stall cycle in FETCH, MEMREAD or MEMWRITE.
- Illegal opcode: 2 cycles. `illegal` pulses for exactly one cycle.
- The outputs decoded from `op` follow IR contents, which are stable from DECODE onward.

## Structure
- Shared package `ctrl_pkg`:
  - `state_t` enum.
  - Opcode constants.
  - ALUOp, ResultSrc, ALUSrcA and ALUSrcB constants.
- ImmSrc constants come from `Imm_pkg`.
- One sub-module: `alu_decoder` (combinational, inputs ALUOp/funct3/op[5]/funct7b5).

## Test plan
1. **lw:** `mem_ready` low for 2 cycles in MEMREAD → sequence FETCH, DECODE, MEMADR, MEMREAD×3, MEMWB. RegWrite=1 only in MEMWB, with ResultSrc=01.
2. **beq:** `zero`=1 → PCWrite=1 in BRANCH. bne with `zero`=1 → PCWrite=0. ALUControl=001 in both cases.
3. **sub:** op=0110011, funct3=000, funct7b5=1 → ALUControl=001 in EXECR. addi with funct7b5=1 → 000.
4. **jal:** ImmSrc=IMM_TypeJ. PCWrite=1 in JAL, then RegWrite=1 in ALUWB. Four cycles total.
5. **Illegal opcode:** op=1111111 → `illegal`=1 for one cycle, then back to FETCH. No write enable asserts.
6. **Async reset:** `rst_n` dropped in MEMWRITE → MemWrite falls to 0 without waiting for `clk`. The FSM restarts in FETCH.

Source files
------------

// File: rtl/Imm_pkg.sv
// Immediate-format encodings shared by the controller and the immediate extender.
package Imm_pkg;

    localparam int unsigned IMM_SRC_W = 3;

    typedef logic [IMM_SRC_W-1:0] imm_src_t;

    localparam imm_src_t IMM_TypeI = 3'b000;
    localparam imm_src_t IMM_TypeS = 3'b001;
    localparam imm_src_t IMM_TypeB = 3'b010;
    localparam imm_src_t IMM_TypeU = 3'b011;
    localparam imm_src_t IMM_TypeJ = 3'b100;

endpackage

// File: rtl/ctrl_pkg.sv
// State encoding, opcodes and datapath select encodings for the multicycle control unit.
package ctrl_pkg;

    localparam int unsigned OP_W   = 7;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned ALUC_W = 3;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK,
        S_LUI, S_AUIPC
    } state_t;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;
    localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'b11;

    localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALUC_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b011;
    localparam logic [ALUC_W-1:0] ALUC_XOR = 3'b100;
    localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b101;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction fields, status flags and datapath controls between controller and datapath.
interface multicycle_ctrl_if;
    import ctrl_pkg::*;
    import Imm_pkg::*;

    logic [OP_W-1:0]   op;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic              zero;
    logic              mem_ready;

    logic              PCWrite;
    logic              AdrSrc;
    logic              MemWrite;
    logic              IRWrite;
    logic              RegWrite;
    logic [SEL_W-1:0]  ResultSrc;
    logic [SEL_W-1:0]  ALUSrcA;
    logic [SEL_W-1:0]  ALUSrcB;
    logic [ALUC_W-1:0] ALUControl;
    imm_src_t          ImmSrc;
    logic              illegal;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal
    );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps the controller's ALUOp plus instruction funct bits to an ALU operation code.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [SEL_W-1:0]  alu_op,
    input  logic [2:0]        funct3,
    input  logic              op5,
    input  logic              funct7b5,
    output logic [ALUC_W-1:0] alu_control
);

    always_comb begin
        alu_control = ALUC_ADD;
        unique case (alu_op)
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                unique case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alu_control = ALUC_SLT;
                    3'b100:  alu_control = ALUC_XOR;
                    3'b110:  alu_control = ALUC_OR;
                    3'b111:  alu_control = ALUC_AND;
                    default: alu_control = ALUC_ADD;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I core: sequences each instruction and
// drives all datapath selects/enables; ImmSrc and ALUControl decode from IR fields.
module multicycle_ctrl
    import ctrl_pkg::*;
    import Imm_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);

    state_t            state, state_next;
    logic [SEL_W-1:0]  alu_op;
    logic [ALUC_W-1:0] alu_control;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                unique case (bus.op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default:           state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_next = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) state_next = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_LUI, S_AUIPC, S_LINK: state_next = S_ALUWB;
            S_JALR:     state_next = S_LINK;
            default:    state_next = S_FETCH;
        endcase
    end

    // Moore outputs; FETCH enables are gated by rst_n so nothing writes while reset is held.
    always_comb begin
        bus.PCWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RD2;
        bus.illegal   = 1'b0;
        alu_op        = ALUOP_ADD;
        unique case (state)
            S_FETCH: begin
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                bus.IRWrite   = bus.mem_ready && rst_n;
                bus.PCWrite   = bus.mem_ready && rst_n;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                unique case (bus.op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
                    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: bus.illegal = 1'b0;
                    default:                           bus.illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECR: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_RD2;
                alu_op      = ALUOP_FUNCT;
            end
            S_EXECI: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
                alu_op      = ALUOP_FUNCT;
            end
            S_ALUWB:    bus.RegWrite = 1'b1;
            S_BRANCH: begin
                bus.ALUSrcA = SRCA_RD1;
                alu_op      = ALUOP_SUB;
                bus.PCWrite = bus.zero ^ bus.funct3[0];
            end
            S_JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                bus.PCWrite = 1'b1;
            end
            S_JALR: begin
                bus.ALUSrcA   = SRCA_RD1;
                bus.ALUSrcB   = SRCB_IMM;
                bus.ResultSrc = RES_ALURESULT;
                bus.PCWrite   = 1'b1;
            end
            S_LINK: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
            end
            S_LUI: begin
                bus.ALUSrcA = SRCA_ZERO;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_AUIPC: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (bus.op)
            OP_LOAD, OP_ITYPE, OP_JALR: bus.ImmSrc = IMM_TypeI;
            OP_STORE:                   bus.ImmSrc = IMM_TypeS;
            OP_BRANCH:                  bus.ImmSrc = IMM_TypeB;
            OP_LUI, OP_AUIPC:           bus.ImmSrc = IMM_TypeU;
            OP_JAL:                     bus.ImmSrc = IMM_TypeJ;
            default:                    bus.ImmSrc = IMM_TypeI;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .op5         (bus.op[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (alu_control)
    );

    assign bus.ALUControl = alu_control;

endmodule
